// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// instr_loader: boot-time program loader for the instruction memory.
// Accepts a framed byte stream: a 16-bit big-endian word count N, then N
// big-endian 32-bit words. Each word is written to sequential word addresses
// 0..N-1. The processor is held in reset until the image is complete.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, a trailing XOR
// checksum byte over all payload bytes is checked in a CHK state.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   in_valid      stream byte valid
//   in_data       stream byte
//   in_ready      loader can accept a byte (decoded from state)
//   reload        request a new load; honoured in DONE/ERROR only
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word address of the write
//   imem_wdata    word to write
//   cpu_hold      1 keeps the processor in reset
//   done          image loaded successfully
//   error         frame rejected
//   words_loaded  number of words written in the current load
module instr_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned WL_W      = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [7:0]  hdr_hi_q;
    logic [15:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        ready_c;
    logic        accept_c;
    logic        last_word_c;
    logic        overflow_c;
    logic        word_done_c;
    logic        stay_done_c;
    logic        stay_error_c;
    logic [15:0] hdr_cnt_c;

    // States that accept stream bytes.
    always_comb begin
        ready_c = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA: ready_c = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                  ready_c = 1'b1;
`endif
            default:                ready_c = 1'b0;
        endcase
    end

    // Gated by reset so the loader never advertises readiness while held.
    assign in_ready     = reset & ready_c;
    assign accept_c     = in_valid & in_ready;
    assign hdr_cnt_c    = {hdr_hi_q, in_data};
    assign overflow_c   = 32'(hdr_cnt_c) > 32'(MAX_WORDS);
    assign last_word_c  = (32'(words_loaded) + 32'd1) == 32'(word_cnt_q);
    assign word_done_c  = accept_c && (state_q == S_DATA) && (byte_cnt_q == 2'd3);
    // Status flags lag state entry by one cycle and drop on the reload edge.
    assign stay_done_c  = (state_q == S_DONE)  && (state_d == S_DONE);
    assign stay_error_c = (state_q == S_ERROR) && (state_d == S_ERROR);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR0: begin
                if (accept_c) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (accept_c) begin
                    if (overflow_c) begin
                        state_d = S_ERROR;
                    end else if (hdr_cnt_c == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done_c && last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_c) state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (reload) state_d = S_HDR0;
            end
            default: state_d = S_HDR0;
        endcase
    end

    // Header capture, word assembly, write port and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_hi_q     <= 8'd0;
            word_cnt_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we  <= 1'b0;
            done     <= stay_done_c;
            error    <= stay_error_c;
            cpu_hold <= ~stay_done_c;

            case (state_q)
                S_HDR0: begin
                    byte_cnt_q <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    xor_q      <= 8'd0;
`endif
                    if (accept_c) hdr_hi_q <= in_data;
                end
                S_HDR1: begin
                    if (accept_c) word_cnt_q <= hdr_cnt_c;
                end
                S_DATA: begin
                    if (accept_c) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        xor_q      <= xor_q ^ in_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {shift_q, in_data};
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            words_loaded <= words_loaded + WL_W'(1);
                        end else begin
                            shift_q <= {shift_q[15:0], in_data};
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (reload) words_loaded <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
// Directed bench for instr_loader: full-rate load, empty image, overflow,
// optional checksum, gapped stream and asynchronous reset mid-frame.
module tb_instr_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int tests_run    = 0;
    int tests_failed = 0;
    int base;

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    logic              log_hold[$];

    logic [7:0]  frame_e[18];
    logic [31:0] exp_e[4];

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_hold.push_back(cpu_hold);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_addr(input int idx);
        if (idx < log_addr.size()) return 64'(log_addr[idx]);
        return 'x;
    endfunction

    function automatic logic [63:0] get_data(input int idx);
        if (idx < log_data.size()) return 64'(log_data[idx]);
        return 'x;
    endfunction

    function automatic logic [63:0] get_hold(input int idx);
        if (idx < log_hold.size()) return 64'(log_hold[idx]);
        return 'x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the rising edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        check("send_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 1)) step();
        send_byte(b);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        frame_e  = '{8'h00, 8'h04,
                     8'h20, 8'h08, 8'h00, 8'h05,
                     8'h00, 8'h00, 8'h00, 8'h08,
                     8'h12, 8'h34, 8'h56, 8'h78,
                     8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_e    = '{32'h20080005, 32'h00000008, 32'h12345678, 32'hDEADBEEF};

        // Reset state
        repeat (3) step();
        check("rst_in_ready",     64'(in_ready),     64'h0);
        check("rst_imem_we",      64'(imem_we),      64'h0);
        check("rst_imem_addr",    64'(imem_addr),    64'h0);
        check("rst_imem_wdata",   64'(imem_wdata),   64'h0);
        check("rst_cpu_hold",     64'(cpu_hold),     64'h1);
        check("rst_done",         64'(done),         64'h0);
        check("rst_error",        64'(error),        64'h0);
        check("rst_words_loaded", 64'(words_loaded), 64'h0);
        reset = 1'b1;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'h1);

        // N=2 at full rate
        base = log_addr.size();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        check("a_we_last",    64'(imem_we),    64'h1);
        check("a_addr_last",  64'(imem_addr),  64'h1);
        check("a_wdata_last", 64'(imem_wdata), 64'h8);
`ifdef LOADER_CHECKSUM_EN
        check("a_chk_ready", 64'(in_ready), 64'h1);
        send_byte(8'h25);
`else
        check("a_ready_done_state", 64'(in_ready), 64'h0);
`endif
        check("a_done_lag", 64'(done),     64'h0);
        check("a_hold_lag", 64'(cpu_hold), 64'h1);
        step();
        check("a_done",     64'(done),         64'h1);
        check("a_cpu_hold", 64'(cpu_hold),     64'h0);
        check("a_in_ready", 64'(in_ready),     64'h0);
        check("a_words",    64'(words_loaded), 64'h2);
        check("a_we_idle",  64'(imem_we),      64'h0);
        check("a_error",    64'(error),        64'h0);
        check("a_nwrites",  64'(log_addr.size() - base), 64'h2);
        check("a_w0_addr",  get_addr(base),     64'h0);
        check("a_w0_data",  get_data(base),     64'h20080005);
        check("a_w1_addr",  get_addr(base + 1), 64'h1);
        check("a_w1_data",  get_data(base + 1), 64'h00000008);
        check("a_hold_at_last_we", get_hold(base + 1), 64'h1);

        pulse_reload();
        check("rl_done",     64'(done),         64'h0);
        check("rl_cpu_hold", 64'(cpu_hold),     64'h1);
        check("rl_in_ready", 64'(in_ready),     64'h1);
        check("rl_words",    64'(words_loaded), 64'h0);

        // N=0 header only
        base = log_addr.size();
        send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        check("z_chk_ready", 64'(in_ready), 64'h1);
        send_byte(8'h00);
`endif
        check("z_ready_done_state", 64'(in_ready), 64'h0);
        check("z_done_lag",         64'(done),     64'h0);
        step();
        check("z_done",     64'(done),         64'h1);
        check("z_cpu_hold", 64'(cpu_hold),     64'h0);
        check("z_words",    64'(words_loaded), 64'h0);
        check("z_error",    64'(error),        64'h0);
        check("z_nwrites",  64'(log_addr.size() - base), 64'h0);
        pulse_reload();

        // N=0x0101 exceeds capacity
        base = log_addr.size();
        send_byte(8'h01); send_byte(8'h01);
        check("o_ready_err_state", 64'(in_ready), 64'h0);
        check("o_error_lag",       64'(error),    64'h0);
        step();
        check("o_error",    64'(error),    64'h1);
        check("o_cpu_hold", 64'(cpu_hold), 64'h1);
        check("o_done",     64'(done),     64'h0);
        step();
        check("o_nwrites",  64'(log_addr.size() - base), 64'h0);
        pulse_reload();
        check("o_rl_error",    64'(error),    64'h0);
        check("o_rl_in_ready", 64'(in_ready), 64'h1);
        check("o_rl_cpu_hold", 64'(cpu_hold), 64'h1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        base = log_addr.size();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
        send_byte(8'h00);
        step();
        check("c_done",    64'(done),  64'h1);
        check("c_error",   64'(error), 64'h0);
        check("c_nwrites", 64'(log_addr.size() - base), 64'h1);
        check("c_w0_addr", get_addr(base), 64'h0);
        check("c_w0_data", get_data(base), 64'hAA550FF0);
        pulse_reload();
        base = log_addr.size();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
        send_byte(8'h01);
        step();
        check("c_bad_error",    64'(error),        64'h1);
        check("c_bad_done",     64'(done),         64'h0);
        check("c_bad_cpu_hold", 64'(cpu_hold),     64'h1);
        check("c_bad_words",    64'(words_loaded), 64'h1);
        check("c_bad_nwrites",  64'(log_addr.size() - base), 64'h1);
        pulse_reload();
`endif

        // 4-word frame with random idle gaps
        base = log_addr.size();
        for (int i = 0; i < 18; i++) send_gap(frame_e[i]);
`ifdef LOADER_CHECKSUM_EN
        send_gap(8'h0F);
`endif
        wait_end();
        check("g_done",    64'(done),         64'h1);
        check("g_error",   64'(error),        64'h0);
        check("g_words",   64'(words_loaded), 64'h4);
        check("g_nwrites", 64'(log_addr.size() - base), 64'h4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("g_w%0d_addr", i), get_addr(base + i), 64'(i));
            check($sformatf("g_w%0d_data", i), get_data(base + i), 64'(exp_e[i]));
        end
        pulse_reload();

        // Asynchronous reset after two payload bytes
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
        #2;
        reset = 1'b0;
        #1;
        check("r_in_ready",   64'(in_ready),     64'h0);
        check("r_imem_we",    64'(imem_we),      64'h0);
        check("r_imem_addr",  64'(imem_addr),    64'h0);
        check("r_imem_wdata", 64'(imem_wdata),   64'h0);
        check("r_cpu_hold",   64'(cpu_hold),     64'h1);
        check("r_done",       64'(done),         64'h0);
        check("r_error",      64'(error),        64'h0);
        check("r_words",      64'(words_loaded), 64'h0);
        step();
        reset = 1'b1;
        #1;
        base = log_addr.size();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h30);
`endif
        step();
        check("r2_done",    64'(done),         64'h1);
        check("r2_words",   64'(words_loaded), 64'h1);
        check("r2_nwrites", 64'(log_addr.size() - base), 64'h1);
        check("r2_w0_addr", get_addr(base), 64'h0);
        check("r2_w0_data", get_data(base), 64'hCAFEBABE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader sitting directly upstream of the processor's instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to sequential instruction-memory word addresses. It holds the processor in reset until the image is fully written. It then releases the processor, which starts fetching from PC 0.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; reset = 0 forces reset state immediately.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on a rising edge with in_valid && in_ready.
- reload  in  1  single-cycle request to start a new load; honoured only in DONE or ERROR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  processor reset request; 1 keeps the processor in reset.
- done  out  1  image loaded successfully.
- error  out  1  frame rejected.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

## Operation
- Frame format: 2-byte word count N (big-endian), then N×4 payload bytes, each word MSB first. The first byte of each word lands in [31:24].
- States:
  - HDR0: accept count high byte.
  - HDR1: accept count low byte.
  - DATA: accept payload bytes.
  - CHK: present only with the macro.
  - DONE.
  - ERROR.
- After HDR1:
  - N > MAX_WORDS → ERROR; no writes occur.
  - N == 0 → CHK, or DONE without the macro.
  - Otherwise → DATA.
- DATA behaviour:
  - A 2-bit byte counter assembles each word.
  - On acceptance of byte 3, the word is registered.
  - imem_addr = word index. Words are written at indices 0..N-1 in order; there is no wrap-around.
  - words_loaded increments with each imem_we.
- in_ready = 1 in HDR0, HDR1, DATA and CHK; 0 in DONE and ERROR. It is decoded from the state register only.
- cpu_hold:
  - 1 in all states except DONE.
  - ERROR keeps the processor held.
- done = 1 only in DONE; error = 1 only in ERROR.
- reload:
  - In DONE or ERROR, reload → HDR0 next cycle. done, error and words_loaded are cleared and cpu_hold is set to 1.
  - Ignored in all other states.
- Instruction-memory contents beyond N are not touched.
- Reset values: state HDR0, in_ready 1 after deassertion (0 while reset = 0), imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, done 0, error 0, words_loaded 0, byte counter 0.
- Reset mid-load returns to HDR0 immediately. Partially written memory is left as-is and is overwritten by the next frame.

## Timing
- One byte per cycle maximum. There is no internal stall; in_valid gaps are tolerated in any state.
- imem_we is registered. It is high for exactly one cycle, the cycle after byte 3 of a word is accepted, with imem_addr and imem_wdata valid in that same cycle.
- Final word without the macro:
  - Cycle after its byte 3 is accepted: imem_we = 1 and the state moves to DONE.
  - done = 1 and cpu_hold = 0 are registered one cycle later, so the release follows the last write strobe by one cycle.
- Header-only paths (N == 0, overflow) move to DONE/ERROR on the cycle after the HDR1 byte is accepted.
- Latency for N words at full rate: 2 + 4N bytes; done rises 2 cycles after the last payload byte is accepted.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A trailing checksum byte follows the payload, equal to the XOR of all 4N payload bytes; the header bytes are excluded.
  - A running XOR register is cleared in HDR0.
  - CHK accepts one byte: match → DONE, mismatch → ERROR. Either way the transition occurs the cycle after acceptance.
  - All words have already been written when ERROR is entered.
- Undefined: the CHK state and the XOR register are absent; DATA completion leads directly to DONE.

## Test plan
- N=2, payload 20 08 00 05 / 00 00 00 08, full rate:
  - Expected writes: addr 0 = 0x20080005, then addr 1 = 0x00000008.
  - Expected end state: words_loaded=2, done=1, cpu_hold=0, in_ready=0.
- N=0 header (00 00):
  - No imem_we.
  - Without the macro, done=1 on the cycle after the second byte.
  - With the macro, one more byte 0x00 is required, then done=1.
- ADDR_W=8, N=0x0101:
  - error=1 after the header; no imem_we; cpu_hold stays 1.
  - reload → HDR0 with error=0.
- With the macro, N=1, payload AA 55 0F F0, checksum 0x00:
  - Expected: write of 0xAA550FF0 to addr 0, then DONE.
  - Repeat with checksum 0x01 → ERROR; cpu_hold stays 1.
- Random in_valid gaps (about 50% duty) on a 4-word frame:
  - Words identical to the full-rate run.
  - Exactly 4 imem_we pulses, one cycle each.
- Reset=0 asserted after 2 payload bytes:
  - Outputs return to reset values asynchronously.
  - A fresh N=1 frame then loads correctly at addr 0.
